muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two operands read from the register file (RD1/RD2) plus the destination index.
- Produces a write-back triple (we_out, rd_out, result) that drives the register file write port (WE3/AD3/WD3).
- Multi-cycle with a start/busy/done handshake; the core stalls while busy is high.

Parameters:
- DATA_WIDTH, 32, operand and result width; only 32 is supported.
- ADDRESS_WIDTH, 5, destination register index width.
- CNT_WIDTH, 5, iteration counter width; must satisfy 2**CNT_WIDTH == DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  DATA_WIDTH  rs1 value (RD1).
- op_b  input  DATA_WIDTH  rs2 value (RD2).
- rd_in  input  ADDRESS_WIDTH  destination register index.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse; result valid.
- result  output  DATA_WIDTH  final value; held until the next accepted start.
- rd_out  output  ADDRESS_WIDTH  latched rd_in.
- we_out  output  1  equals done AND (rd_out != 0); drives WE3.

Behaviour:
- Reset value: rst=1 at a clock edge forces state IDLE with busy=0, done=0, we_out=0, result=0, rd_out=0 and counter=0.
- Reset mid-operation: rst aborts any operation in progress. No done and no we_out are produced for the aborted operation.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On start=1, latch funct3, rd_in and the operand magnitudes plus sign flags.
  - Next state is CALC with counter=0, except for the DONE shortcuts below, which go straight to DONE.
  - start=0 keeps the FSM in IDLE.
- CALC:
  - One iteration per cycle; the counter increments each cycle.
  - After the iteration with counter=31, the next state is DONE.
- DONE:
  - done=1 and result is valid; the next state is IDLE.
  - A start seen in the DONE cycle is ignored; it must be re-presented in IDLE.
- Latency: start sampled at edge E0 with a normal op gives done=1 in the cycle after edge E32, i.e. 33 cycles from the start edge.
- DONE shortcuts: when start is sampled at E0, done=1 in the cycle after E0 for:
  - divisor==0;
  - signed overflow, DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF.
- Start while busy=1 is ignored; the latched operands must not change.
- Multiply:
  - Shift-add on magnitudes: 32-bit multiplicand, 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - MUL and MULHU use unsigned operands.
  - MULH negates the 64-bit product if sign(a) XOR sign(b).
  - MULHSU treats only op_a as signed; the sign fix uses sign(a).
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32]. MUL low bits are identical signed or unsigned.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle, MSB first.
  - DIV: quotient negated if sign(a) XOR sign(b).
  - REM: remainder takes the sign of op_a.
  - DIVU and REMU are unsigned.
- Divisor zero:
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return op_a unchanged.
- Signed overflow: DIV returns 0x80000000; REM returns 0.
- Write-back guard: rd_in=0 still executes and pulses done, but we_out stays 0.
- Operand ports are sampled only at acceptance. Changes during CALC have no effect.

Optional Feature:
- Macro name: MULDIV_FAST_MUL_EN.
- Defined:
  - All four multiply ops use a single-cycle combinational 33x33 signed product on the latched operands.
  - Multiplies take the DONE shortcut with 1-cycle latency, i.e. done in the cycle after the start edge.
  - Division timing is unchanged.
- Undefined:
  - The iterative shift-add path applies with 33-cycle latency.
  - No multiplier is inferred.
- Results must be bit-identical in both builds.

Test Plan:
- Reset, then MUL with a=7, b=6, rd=5: done exactly 33 cycles after start, result=42, rd_out=5, we_out=1. With MULDIV_FAST_MUL_EN, done after 1 cycle with the same values.
- MULH a=0xFFFFFFFF (-1), b=2 -> 0xFFFFFFFF. MULHU with the same operands -> 0x00000001. MULHSU with the same operands -> 0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU with the same operands -> 2. Each completes in 33 cycles.
- Divisor zero:
  - DIVU a=123, b=0 -> 0xFFFFFFFF in 1 cycle.
  - REM a=123, b=0 -> 123 in 1 cycle.
- Signed overflow:
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 in 1 cycle.
  - REM with the same operands -> 0 in 1 cycle.
- Busy-ignore and reset abort:
  - Start DIVU 100/7, then pulse start with new operands at cycle 10 -> ignored, and the first op still completes with result=14.
  - Start again, then assert rst at cycle 15 -> busy=0 next cycle, no done or we_out, result=0.
  - Finally run a MUL with rd=0 -> done=1, we_out=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port.
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiplies; division stays iterative.
module muldiv_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int CNT_WIDTH     = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               funct3,
   input  logic [DATA_WIDTH-1:0]    op_a,
   input  logic [DATA_WIDTH-1:0]    op_b,
   input  logic [ADDRESS_WIDTH-1:0] rd_in,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    result,
   output logic [ADDRESS_WIDTH-1:0] rd_out,
   output logic                     we_out
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic [2:0]               f3_q, f3_d;
   logic                     neg_q, neg_d;
   logic [2*W-1:0]           acc_q, acc_d;
   logic [W-1:0]             mag_q, mag_d;
   logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
   logic [W-1:0]             res_q, res_d;

   // Operand decode at acceptance time.
   logic           is_div, signed_a, signed_b, a_neg, b_neg;
   logic [W-1:0]   a_mag, b_mag;

   // One iteration of either algorithm on the shared accumulator.
   logic [W:0]     mul_sum;
   logic [W:0]     div_shifted;
   logic           div_ge;
   logic [W-1:0]   div_diff;
   logic [2*W-1:0] acc_step;

`ifdef MULDIV_FAST_MUL_EN
   logic [2*W-1:0] fast_a, fast_b, fast_prod;
`endif

   function automatic logic [W-1:0] finalize(input logic [2:0] f3, input logic neg,
                                             input logic [2*W-1:0] acc);
      logic [2*W-1:0] prod;
      logic [W-1:0]   dv;
      prod = neg ? -acc : acc;
      if (!f3[2]) begin
         return (f3[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
      end
      dv = f3[1] ? acc[2*W-1:W] : acc[W-1:0];
      return neg ? -dv : dv;
   endfunction

   always_comb begin
      is_div   = funct3[2];
      signed_a = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
      signed_b = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
      a_neg    = signed_a & op_a[W-1];
      b_neg    = signed_b & op_b[W-1];
      a_mag    = a_neg ? -op_a : op_a;
      b_mag    = b_neg ? -op_b : op_b;
   end

   always_comb begin
      // Multiply: add multiplicand into the high half when the current LSB is set, then shift right.
      mul_sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_q} : '0);
      // Divide: shift the next dividend bit into the partial remainder and try to subtract.
      div_shifted = {acc_q[2*W-1:W], acc_q[W-1]};
      div_ge      = div_shifted >= {1'b0, mag_q};
      div_diff    = div_shifted[W-1:0] - mag_q;
      if (f3_q[2]) begin
         acc_step = div_ge ? {div_diff, acc_q[W-2:0], 1'b1}
                           : {acc_q[2*W-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc_q[W-1:1]};
      end
   end

`ifdef MULDIV_FAST_MUL_EN
   // Sign-extended to 2W bits, so the truncated product equals the 33x33 signed product's low 64 bits.
   always_comb begin
      fast_a    = {{W{signed_a & op_a[W-1]}}, op_a};
      fast_b    = {{W{signed_b & op_b[W-1]}}, op_b};
      fast_prod = fast_a * fast_b;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      mag_d   = mag_q;
      rd_d    = rd_q;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CALC;
               cnt_d   = '0;
               f3_d    = funct3;
               rd_d    = rd_in;
               neg_d   = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
               if (is_div) begin
                  acc_d = {{W{1'b0}}, a_mag};
                  mag_d = b_mag;
               end else begin
                  acc_d = {{W{1'b0}}, b_mag};
                  mag_d = a_mag;
               end
               if (is_div && op_b == '0) begin
                  state_d = S_DONE;
                  res_d   = funct3[1] ? op_a : '1;
               end else if (is_div && !funct3[0] && op_a == INT_MIN && op_b == '1) begin
                  state_d = S_DONE;
                  res_d   = funct3[1] ? '0 : INT_MIN;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!is_div) begin
                  state_d = S_DONE;
                  res_d   = (funct3[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
               end
`endif
            end
         end
         S_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == '1) begin
               state_d = S_DONE;
               res_d   = finalize(f3_q, neg_q, acc_step);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: every state register uses non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         mag_q   <= '0;
         rd_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         mag_q   <= mag_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);
   assign we_out = done && (rd_q != '0);
   assign result = res_q;
   assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;
   localparam int BUDGET  = 60;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        busy, done, we_out;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out),
      .we_out (we_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the unit idle; returns at the negedge right after the start edge.
   task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      start  = 1'b1;
      funct3 = f3;
      op_a   = a;
      op_b   = b;
      rd_in  = rd;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (!done && lat < BUDGET) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      start_op(f3, a, b, rd);
      wait_done(1, lat);
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".result"}, result, exp);
      check({tag, ".rd_out"}, {27'd0, rd_out}, {27'd0, rd});
      check({tag, ".we_out"}, {31'd0, we_out}, {31'd0, rd != 5'd0});
      check({tag, ".busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, ".held"}, result, exp);
   endtask

   initial begin
      int lat;
      int done_seen;
      rst    = 1'b1;
      start  = 1'b0;
      funct3 = '0;
      op_a   = '0;
      op_b   = '0;
      rd_in  = '0;
      repeat (3) @(negedge clk);
      check("reset.busy",   {31'd0, busy},   32'd0);
      check("reset.done",   {31'd0, done},   32'd0);
      check("reset.we_out", {31'd0, we_out}, 32'd0);
      check("reset.result", result,          32'd0);
      check("reset.rd_out", {27'd0, rd_out}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("mul_7x6",      F_MUL,    32'd7,        32'd6,        5'd5,  32'd42,       MUL_LAT);
      run_op("mul_m1xm1",    F_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'd1,        MUL_LAT);
      run_op("mulh_m1x2",    F_MULH,   32'hFFFFFFFF, 32'd2,        5'd2,  32'hFFFFFFFF, MUL_LAT);
      run_op("mulhu_m1x2",   F_MULHU,  32'hFFFFFFFF, 32'd2,        5'd3,  32'h00000001, MUL_LAT);
      run_op("mulhsu_m1x2",  F_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, MUL_LAT);
      run_op("mulh_min_sq",  F_MULH,   32'h80000000, 32'h80000000, 5'd6,  32'h40000000, MUL_LAT);
      run_op("div_m7_2",     F_DIV,    32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, DIV_LAT);
      run_op("rem_m7_2",     F_REM,    32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, DIV_LAT);
      run_op("div_7_m2",     F_DIV,    32'd7,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD, DIV_LAT);
      run_op("rem_7_m2",     F_REM,    32'd7,        32'hFFFFFFFE, 5'd10, 32'd1,        DIV_LAT);
      run_op("divu_100_7",   F_DIVU,   32'd100,      32'd7,        5'd11, 32'd14,       DIV_LAT);
      run_op("remu_100_7",   F_REMU,   32'd100,      32'd7,        5'd12, 32'd2,        DIV_LAT);
      run_op("divu_max_1",   F_DIVU,   32'hFFFFFFFF, 32'd1,        5'd13, 32'hFFFFFFFF, DIV_LAT);
      run_op("divu_by0",     F_DIVU,   32'd123,      32'd0,        5'd14, 32'hFFFFFFFF, 1);
      run_op("rem_by0",      F_REM,    32'd123,      32'd0,        5'd15, 32'd123,      1);
      run_op("div_ovf",      F_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
      run_op("rem_ovf",      F_REM,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        1);

      // A second start while busy must not disturb the latched operands or rd.
      start_op(F_DIVU, 32'd100, 32'd7, 5'd20);
      repeat (8) @(negedge clk);
      start_op(F_MULHU, 32'd200, 32'd3, 5'd21);
      check("ignore.busy", {31'd0, busy}, 32'd1);
      wait_done(10, lat);
      check("ignore.latency", 32'(lat), 32'(DIV_LAT));
      check("ignore.result",  result,   32'd14);
      check("ignore.rd_out",  {27'd0, rd_out}, 32'd20);
      @(negedge clk);

      // Reset mid-operation aborts without a done or write-back.
      start_op(F_DIVU, 32'd100, 32'd7, 5'd9);
      repeat (13) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.busy",   {31'd0, busy},   32'd0);
      check("abort.done",   {31'd0, done},   32'd0);
      check("abort.we_out", {31'd0, we_out}, 32'd0);
      check("abort.result", result,          32'd0);
      check("abort.rd_out", {27'd0, rd_out}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || we_out) done_seen++;
      end
      check("abort.no_done", 32'(done_seen), 32'd0);

      run_op("mul_rd0", F_MUL, 32'd3, 32'd5, 5'd0, 32'd15, MUL_LAT);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
